// File: rtl/mem_if_pkg.sv
// Shared encodings and defaults for the data-memory initiator slice.
// Constants and a helper function only; no latency and no backpressure.
// Holds the FSM state codes, the default bus widths and the LED register address.
package mem_if_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam logic [15:0] MMIO_LED_ADDR_DEF = 16'hBF00;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETUP  = 3'd1;
   localparam logic [2:0] STROBE = 3'd2;
   localparam logic [2:0] HOLD   = 3'd3;
   localparam logic [2:0] RESP   = 3'd4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mem_phase_counter.sv
// Phase timer: counts enabled cycles and pulses done on the tc-th cycle of a phase.
// done is combinational from the count, so a phase of tc cycles ends on its last edge.
// No backpressure; clear (or done) returns the count to zero, so it never wraps.
module mem_phase_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic [CNT_W-1:0] tc,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   assign done = en && (cnt == tc - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || done) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/data_mem_initiator.sv
// Load/store initiator for the data memory and LED register; optional LED_SHADOW_EN shadow.
// Latency: SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles from accept to rsp_valid (4 by default).
// One request in flight; req_ready stays low until the response is taken on rsp_ready.
module data_mem_initiator
   import mem_if_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
`ifdef LED_SHADOW_EN
   parameter logic [ADDR_W-1:0] MMIO_LED_ADDR = ADDR_W'(MMIO_LED_ADDR_DEF),
`endif
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 1,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

   logic [2:0]        state;
   logic              we_q;
   logic              timed;
   logic              phase_done;
   logic [CNT_W-1:0]  tc;
   logic [DATA_W-1:0] load_data;

   assign busy  = (state != IDLE);
   assign timed = (state == SETUP) || (state == STROBE) || (state == HOLD);

   always_comb begin
      tc = CNT_W'(SETUP_CYC);
      if (state == STROBE) begin
         tc = CNT_W'(STROBE_CYC);
      end else if (state == HOLD) begin
         tc = CNT_W'(HOLD_CYC);
      end
   end

   mem_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (timed),
      .clear (!timed),
      .tc    (tc),
      .done  (phase_done)
   );

`ifdef LED_SHADOW_EN
   logic [DATA_W-1:0] led_shadow;
   logic              led_hit;

   assign led_hit   = (mem_address == MMIO_LED_ADDR);
   assign load_data = led_hit ? led_shadow : mem_rdata;

   // Shadow tracks the LED register at the same point the strobe completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_shadow <= '0;
      end else if (state == STROBE && phase_done && we_q && led_hit) begin
         led_shadow <= mem_wdata;
      end
   end
`else
   assign load_data = mem_rdata;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_write   <= 1'b0;
         we_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state       <= SETUP;
                  req_ready   <= 1'b0;
                  mem_address <= req_addr;
                  mem_wdata   <= req_wdata;
                  we_q        <= req_we;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            SETUP: begin
               if (phase_done) begin
                  state     <= STROBE;
                  mem_write <= we_q;
               end
            end
            STROBE: begin
               if (phase_done) begin
                  state     <= HOLD;
                  mem_write <= 1'b0;
                  if (!we_q) begin
                     rsp_rdata <= load_data;
                  end
               end
            end
            HOLD: begin
               if (phase_done) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator: default timing on one instance,
// stretched phases (2/3/2) on a second, with a small memory model behind the first.
module tb_data_mem_initiator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_rdata;
   logic [15:0] mem_address, mem_wdata, mem_rdata;
   logic        mem_write, busy;

   logic        req_valid_b, req_ready_b, req_we_b;
   logic [15:0] req_addr_b, req_wdata_b;
   logic        rsp_valid_b, rsp_ready_b;
   logic [15:0] rsp_rdata_b;
   logic [15:0] mem_address_b, mem_wdata_b;
   logic        mem_write_b, busy_b;

   int  checks = 0;
   int  errors = 0;
   time accept_time;

   logic [15:0] mem [0:255];
   logic [15:0] led_reg = 16'h0000;
   int          wr_rises = 0;

   // Memory commits on the rising strobe; reads of the LED address return a fixed tag.
   always @(posedge mem_write) begin
      wr_rises = wr_rises + 1;
      if (mem_address == 16'hBF00) led_reg = mem_wdata;
      else mem[mem_address[7:0]] = mem_wdata;
   end
   assign mem_rdata = (mem_address == 16'hBF00) ? 16'hDEAD : mem[mem_address[7:0]];

   data_mem_initiator dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   data_mem_initiator #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_long (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
      .mem_address(mem_address_b), .mem_wdata(mem_wdata_b), .mem_write(mem_write_b),
      .mem_rdata(16'h0000), .busy(busy_b)
   );

   // Runs one transaction from just after an edge with req_ready high; cycle 1 is the
   // cycle after the accept edge. With hammer, req_valid stays high with junk fields.
   task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int rdy_delay, input logic hammer,
                         output int wr_first, output int wr_cnt, output int rv_first,
                         output logic [15:0] rdata, output logic hold_ok, output logic addr_ok);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      accept_time = $time;
      #1;
      if (hammer) begin
         req_we = 1'b1; req_addr = 16'h0077; req_wdata = 16'hBEEF;
      end else begin
         req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 16'hFFFF;
      end
      wr_first = -1; wr_cnt = 0; rv_first = -1; rdata = '0; hold_ok = 1'b1; addr_ok = 1'b1;
      for (int cyc = 1; cyc < 40; cyc++) begin
         if (mem_write) begin
            if (wr_first < 0) wr_first = cyc;
            wr_cnt++;
         end
         if (mem_address !== addr || mem_wdata !== wdata) addr_ok = 1'b0;
         if (rsp_valid) begin
            if (rv_first < 0) begin
               rv_first = cyc;
               rdata = rsp_rdata;
            end
            if (rsp_rdata !== rdata || req_ready !== 1'b0) hold_ok = 1'b0;
            if (cyc - rv_first >= rdy_delay) begin
               rsp_ready = 1'b1;
               @(posedge clk); #1;
               rsp_ready = 1'b0;
               req_valid = 1'b0;
               break;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      #1;
      checks++;
      if ({req_ready, rsp_valid, mem_write, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy/vld/wr/busy=%b expected 0000",
                  {req_ready, rsp_valid, mem_write, busy});
      end
      checks++;
      if (mem_address !== 16'h0 || mem_wdata !== 16'h0 || rsp_rdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0000",
                  mem_address, mem_wdata, rsp_rdata);
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdy_before_edge: got %b expected 0", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdy_after_edge: got rdy=%b busy=%b expected 1/0", req_ready, busy);
      end
   endtask

   task automatic test_store();
      int wf, wc, rv, r0; logic [15:0] rd; logic hok, aok;
      r0 = wr_rises;
      do_txn(1'b1, 16'h0010, 16'h1234, 0, 1'b0, wf, wc, rv, rd, hok, aok);
      checks++;
      if (wf !== 2 || wc !== 1 || wr_rises - r0 !== 1) begin
         errors++;
         $display("FAIL store_strobe: got first=%0d cycles=%0d rises=%0d expected 2/1/1",
                  wf, wc, wr_rises - r0);
      end
      checks++;
      if (rv !== 4) begin
         errors++;
         $display("FAIL store_rsp_cycle: got %0d expected 4", rv);
      end
      checks++;
      if (aok !== 1'b1 || mem[8'h10] !== 16'h1234) begin
         errors++;
         $display("FAIL store_commit: got stable=%b mem=%h expected 1/1234", aok, mem[8'h10]);
      end
   endtask

   task automatic test_load();
      int wf, wc, rv, r0; logic [15:0] rd; logic hok, aok;
      r0 = wr_rises;
      do_txn(1'b0, 16'h0010, 16'h0000, 0, 1'b0, wf, wc, rv, rd, hok, aok);
      checks++;
      if (rd !== 16'h1234) begin
         errors++;
         $display("FAIL load_rdata: got %h expected 1234", rd);
      end
      checks++;
      if (wc !== 0 || wr_rises - r0 !== 0 || rv !== 4) begin
         errors++;
         $display("FAIL load_no_strobe: got cycles=%0d rises=%0d rsp=%0d expected 0/0/4",
                  wc, wr_rises - r0, rv);
      end
   endtask

   task automatic test_led();
      int wf, wc, rv; logic [15:0] rd, exp; logic hok, aok;
`ifdef LED_SHADOW_EN
      exp = 16'h00A5;
`else
      exp = 16'hDEAD;
`endif
      do_txn(1'b1, 16'hBF00, 16'h00A5, 0, 1'b0, wf, wc, rv, rd, hok, aok);
      checks++;
      if (led_reg !== 16'h00A5 || wf !== 2 || rv !== 4) begin
         errors++;
         $display("FAIL led_store: got led=%h first=%0d rsp=%0d expected 00a5/2/4", led_reg, wf, rv);
      end
      do_txn(1'b0, 16'hBF00, 16'h0000, 0, 1'b0, wf, wc, rv, rd, hok, aok);
      checks++;
      if (rd !== exp || rv !== 4) begin
         errors++;
         $display("FAIL led_load: got rdata=%h rsp=%0d expected %h/4", rd, rv, exp);
      end
   endtask

   task automatic test_rsp_backpressure();
      int wf, wc, rv; logic [15:0] rd; logic hok, aok;
      do_txn(1'b0, 16'h0010, 16'h0000, 3, 1'b1, wf, wc, rv, rd, hok, aok);
      checks++;
      if (rd !== 16'h1234 || hok !== 1'b1 || rv !== 4) begin
         errors++;
         $display("FAIL bp_hold: got rdata=%h stable=%b rsp=%0d expected 1234/1/4", rd, hok, rv);
      end
      checks++;
      if (busy !== 1'b0 || mem_address !== 16'h0010 || aok !== 1'b1) begin
         errors++;
         $display("FAIL bp_ignore_req: got busy=%b addr=%h stable=%b expected 0/0010/1",
                  busy, mem_address, aok);
      end
   endtask

   task automatic test_back_to_back();
      int wf, wc, rv; logic [15:0] rd; logic hok, aok; time t0;
      do_txn(1'b1, 16'h0030, 16'hCAFE, 0, 1'b0, wf, wc, rv, rd, hok, aok);
      t0 = accept_time;
      do_txn(1'b0, 16'h0030, 16'h0000, 0, 1'b0, wf, wc, rv, rd, hok, aok);
      checks++;
      if (accept_time - t0 !== 50) begin
         errors++;
         $display("FAIL b2b_spacing: got %0t expected 50", accept_time - t0);
      end
      checks++;
      if (rd !== 16'hCAFE) begin
         errors++;
         $display("FAIL b2b_rdata: got %h expected cafe", rd);
      end
   endtask

   task automatic test_reset_mid_strobe();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mem_write !== 1'b1) begin
         errors++;
         $display("FAIL rst_strobe_high: got %b expected 1", mem_write);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_write, busy, rsp_valid, req_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_async_drop: got wr/busy/vld/rdy=%b expected 0000",
                  {mem_write, busy, rsp_valid, req_ready});
      end
      checks++;
      if (mem[8'h20] !== 16'h5555) begin
         errors++;
         $display("FAIL rst_committed: got %h expected 5555", mem[8'h20]);
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_rdy_release: got %b expected 0", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_rdy_edge: got rdy=%b vld=%b expected 1/0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_long_phases();
      int wf, wc, rv;
      wf = -1; wc = 0; rv = -1;
      req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 16'h0040; req_wdata_b = 16'h0F0F;
      @(posedge clk); #1;
      req_valid_b = 1'b0;
      for (int cyc = 1; cyc < 40; cyc++) begin
         if (mem_write_b) begin
            if (wf < 0) wf = cyc;
            wc++;
         end
         if (rsp_valid_b) begin
            rv = cyc;
            rsp_ready_b = 1'b1;
            @(posedge clk); #1;
            rsp_ready_b = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (wf !== 3 || wc !== 3) begin
         errors++;
         $display("FAIL long_strobe: got first=%0d cycles=%0d expected 3/3", wf, wc);
      end
      checks++;
      if (rv !== 8 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL long_rsp_cycle: got rsp=%0d busy=%b expected 8/0", rv, busy_b);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_led();
      test_rsp_backpressure();
      test_back_to_back();
      test_reset_mid_strobe();
      test_long_phases();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
